// File: rtl/arm_pkg.sv
// Shared ARM condition/status definitions: cond-code enum and flag bit positions.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package arm_pkg;

   // Condition field [31:28] encodings
   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   // Bit positions inside the {N,Z,C,V} status vector
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef logic [3:0] flags_t;

endpackage

// File: rtl/cond_eval.sv
// Decodes a 4-bit ARM condition field against {N,Z,C,V} flags.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module cond_eval
   import arm_pkg::*;
(
   input  logic [3:0] cond,
   input  flags_t     flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   // Condition decode; NV is reserved and never passes
   always_comb begin
      pass = 1'b0;
      case (cond_e'(cond))
         EQ: pass = z;
         NE: pass = !z;
         CS: pass = c;
         CC: pass = !c;
         MI: pass = n;
         PL: pass = !n;
         VS: pass = v;
         VC: pass = !v;
         HI: pass = c & !z;
         LS: pass = !c | z;
         GE: pass = (n == v);
         LT: pass = (n != v);
         GT: pass = !z & (n == v);
         LE: pass = z | (n != v);
         AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_status_unit.sv
// Architectural NZCV register plus registered condition check of the ID-stage instruction.
// Latency: status_q and cond_pass/pass_valid update one cycle after inputs; c_out is combinational from status_q.
// Backpressure: stall holds the pass register, flush clears it; the status register ignores both.
module cond_status_unit
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] status_bits_in,
   input  logic       exe_valid,
   input  logic       s_update,
   input  logic       id_valid,
   input  logic [3:0] cond,
   input  logic       stall,
   input  logic       flush,
   output logic [3:0] status_q,
   output logic       c_out,
   output logic       cond_pass,
   output logic       pass_valid
);

   logic   flag_wr;
   flags_t fwd;
   logic   eval;

   // A flag-setting EXE instruction is visible to the ID check in the same cycle
   assign flag_wr = exe_valid & s_update;
   assign fwd     = flag_wr ? status_bits_in : status_q;

   // Carry into the ALU comes from committed flags only
   assign c_out = status_q[FLAG_C];

   cond_eval u_cond_eval (
      .cond  (cond),
      .flags (fwd),
      .pass  (eval)
   );

   // Status register: written by valid S-bit instructions, independent of stall/flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= 4'b0000;
      end else if (flag_wr) begin
         status_q <= status_bits_in;
      end
   end

   // Pass register: flush clears, stall holds, otherwise capture the current evaluation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cond_pass  <= 1'b0;
         pass_valid <= 1'b0;
      end else if (flush) begin
         cond_pass  <= 1'b0;
         pass_valid <= 1'b0;
      end else if (!stall) begin
         cond_pass  <= eval & id_valid;
         pass_valid <= id_valid;
      end
   end

endmodule

// File: doc/cond_status_unit.md
COND_STATUS_UNIT -- requirements
Module: cond_status_unit

Interface
REQ-001 SHALL have parameters: none; all widths are fixed by the shared package.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: status_bits_in  input  4  {N,Z,C,V} from the EXE-stage ALU.
REQ-005 SHALL have port: exe_valid  input  1  the EXE-stage instruction is valid (not a bubble).
REQ-006 SHALL have port: s_update  input  1  the EXE-stage instruction has its S bit set.
REQ-007 SHALL have port: id_valid  input  1  the ID-stage instruction is valid.
REQ-008 SHALL have port: cond  input  4  condition field [31:28] of the ID-stage instruction.
REQ-009 SHALL have port: stall  input  1  hold the ID/EXE boundary.
REQ-010 SHALL have port: flush  input  1  discard the ID-stage instruction.
REQ-011 SHALL have port: status_q  output  4  architectural {N,Z,C,V} register.
REQ-012 SHALL have port: c_out  output  1  status_q[C], feeding the ALU carry input.
REQ-013 SHALL have port: cond_pass  output  1  registered result of the condition evaluation.
REQ-014 SHALL have port: pass_valid  output  1  registered flag: cond_pass belongs to a valid instruction.

Function
REQ-015 SHALL write status_q <= status_bits_in on a clock edge where exe_valid=1 and s_update=1; otherwise status_q holds.
REQ-016 SHALL update status_q independently of stall and flush.
REQ-017 SHALL evaluate cond against the forwarded flags fwd = (exe_valid & s_update) ? status_bits_in : status_q.
- The flag writer one instruction ahead therefore has zero-cycle visibility, with no stall.
REQ-018 SHALL decode cond as follows:
- EQ 0000 = Z; NE 0001 = !Z; CS 0010 = C; CC 0011 = !C.
- MI 0100 = N; PL 0101 = !N; VS 0110 = V; VC 0111 = !V.
- HI 1000 = C & !Z; LS 1001 = !C | Z.
- GE 1010 = N == V; LT 1011 = N != V.
- GT 1100 = !Z & (N == V); LE 1101 = Z | (N != V).
- AL 1110 = 1; NV 1111 = 0 (reserved, never passes).
REQ-019 SHALL update the output register with one-cycle latency: on an edge with flush=0 and stall=0, cond_pass <= eval & id_valid and pass_valid <= id_valid.
REQ-020 SHALL hold cond_pass and pass_valid unchanged on an edge with stall=1 and flush=0.
REQ-021 SHALL clear cond_pass and pass_valid to 0 on an edge with flush=1, regardless of stall (flush has priority).
REQ-022 SHALL drive c_out combinationally from status_q[C], never from the forwarded value.
REQ-023 SHALL re-evaluate a stalled ID instruction each cycle, and SHALL capture the flags current at the release edge.

Reset
REQ-024 SHALL clear status_q, cond_pass and pass_valid to 0 immediately when rst_n=0, independently of clk.
REQ-025 SHALL leave c_out at 0 during reset.
REQ-026 SHALL ignore all inputs while rst_n=0; the first update occurs at the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL take the following from the shared arm_pkg package:
- cond-code enum (EQ..NV);
- status bit index constants N=3, Z=2, C=1, V=0.
REQ-028 SHALL place the REQ-018 decode in one combinational sub-module, cond_eval (inputs cond and flags, output pass).

Verification
REQ-029 SHALL cover reset: with rst_n=0 mid-run while status_q=4'b1111, status_q=0, pass_valid=0 and c_out=0 before the next clock edge.
REQ-030 SHALL cover forwarding: status_q=0, exe_valid=1, s_update=1, status_bits_in=4'b0100, cond=EQ, id_valid=1 -> after the edge, cond_pass=1 and status_q=4'b0100.
REQ-031 SHALL cover the no-update case: s_update=0 with status_bits_in=4'b0100 and status_q=0, cond=EQ -> cond_pass=0 and status_q stays 0.
REQ-032 SHALL cover stall/flush priority:
- stall=1 holds cond_pass=1 for 3 cycles;
- stall=1 with flush=1 -> cond_pass=0, pass_valid=0, and status_q still updates.
REQ-033 SHALL cover a full table sweep: all 16 cond values x all 16 flag patterns, checked against REQ-018 (for example GT with 4'b1001 -> 1; NV -> always 0).
REQ-034 SHALL cover id_valid=0 with cond=AL -> cond_pass=0, pass_valid=0.
